// File: rtl/hazard_scoreboard_if.sv
// Decode/execute hazard-check bus shared by the pipeline and hazard_scoreboard.
// HAZARD_PERF_CNT_EN adds the two performance counter outputs.
interface hazard_scoreboard_if #(
    parameter int REG_ADDR_W = 5
);
    localparam int NUM_REGS = 2**REG_ADDR_W;

    logic [REG_ADDR_W-1:0] i_rs1_addr_decode;
    logic [REG_ADDR_W-1:0] i_rs2_addr_decode;
    logic                  i_rs1_used_decode;
    logic                  i_rs2_used_decode;
    logic [REG_ADDR_W-1:0] i_rd_addr_execute;
    logic                  i_rd_wren_execute;
    logic [1:0]            i_wb_sel_execute;
    logic                  i_valid_execute;
    logic                  i_stall_lsu;
    logic                  i_flush;
    logic                  o_stall;
    logic                  o_bubble;
    logic [NUM_REGS-1:0]   o_pending_mask;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]           o_bubble_cnt;
    logic [31:0]           o_lsu_stall_cnt;
`endif

    modport master (
        output i_rs1_addr_decode, i_rs2_addr_decode, i_rs1_used_decode, i_rs2_used_decode,
        output i_rd_addr_execute, i_rd_wren_execute, i_wb_sel_execute, i_valid_execute,
        output i_stall_lsu, i_flush,
        input  o_stall, o_bubble, o_pending_mask
`ifdef HAZARD_PERF_CNT_EN
        , input o_bubble_cnt, o_lsu_stall_cnt
`endif
    );

    modport slave (
        input  i_rs1_addr_decode, i_rs2_addr_decode, i_rs1_used_decode, i_rs2_used_decode,
        input  i_rd_addr_execute, i_rd_wren_execute, i_wb_sel_execute, i_valid_execute,
        input  i_stall_lsu, i_flush,
        output o_stall, o_bubble, o_pending_mask
`ifdef HAZARD_PERF_CNT_EN
        , output o_bubble_cnt, o_lsu_stall_cnt
`endif
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Load-use hazard unit with a per-register pending-latency scoreboard.
// Optional macro HAZARD_PERF_CNT_EN adds saturating bubble / LSU-stall counters.
module hazard_scoreboard #(
    parameter int          REG_ADDR_W  = 5,
    parameter int          LOAD_LAT    = 1,
    parameter logic [1:0]  LOAD_WB_SEL = 2'b00
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    hazard_scoreboard_if.slave   bus
);
    localparam int NUM_REGS = 2**REG_ADDR_W;
    localparam int CNT_W    = 3;
    localparam logic [CNT_W-1:0]      RELOAD   = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0]      CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};

    logic [CNT_W-1:0]    pending_q [NUM_REGS];
    logic [CNT_W-1:0]    pending_d [NUM_REGS];
    logic                ex_write_s;
    logic                ex_load_s;
    logic                hit1_s;
    logic                hit2_s;
    logic                hazard_s;
    logic                stall_s;
    logic                bubble_s;
    logic [NUM_REGS-1:0] mask_s;

    function automatic logic src_hit(
        input logic                  used,
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  ex_load,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [CNT_W-1:0]      pend
    );
        return used & (rs != REG_ZERO) & ((ex_load & (rs == rd)) | (pend != CNT_ZERO));
    endfunction

    // Classify the execute instruction and evaluate the decode-side hazard.
    always_comb begin
        ex_write_s = bus.i_valid_execute & bus.i_rd_wren_execute &
                     (bus.i_rd_addr_execute != REG_ZERO);
        ex_load_s  = ex_write_s & (bus.i_wb_sel_execute == LOAD_WB_SEL);
        hit1_s     = src_hit(bus.i_rs1_used_decode, bus.i_rs1_addr_decode, ex_load_s,
                             bus.i_rd_addr_execute, pending_q[bus.i_rs1_addr_decode]);
        hit2_s     = src_hit(bus.i_rs2_used_decode, bus.i_rs2_addr_decode, ex_load_s,
                             bus.i_rd_addr_execute, pending_q[bus.i_rs2_addr_decode]);
        // Under reset only the LSU freeze may hold the front end.
        hazard_s   = (hit1_s | hit2_s) & i_rst_n;
        stall_s    = bus.i_stall_lsu | (hazard_s & ~bus.i_flush);
        bubble_s   = hazard_s & ~bus.i_flush & ~bus.i_stall_lsu;
    end

    // Scoreboard next state: age every entry, then record the advancing EX writer.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            pending_d[r] = pending_q[r];
        end
        if (!bus.i_stall_lsu) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (pending_q[r] != CNT_ZERO) begin
                    pending_d[r] = pending_q[r] - {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    pending_d[r] = pending_q[r];
                end
            end
            // A younger ALU writer supersedes the load, so its entry is cleared.
            if (!bus.i_flush && ex_load_s) begin
                pending_d[bus.i_rd_addr_execute] = RELOAD;
            end else if (!bus.i_flush && ex_write_s) begin
                pending_d[bus.i_rd_addr_execute] = CNT_ZERO;
            end else begin
                pending_d[0] = CNT_ZERO;
            end
        end else begin
            pending_d[0] = CNT_ZERO;
        end
        pending_d[0] = CNT_ZERO;
    end

    // Pending counter storage.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pending_q[r] <= CNT_ZERO;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pending_q[r] <= pending_d[r];
            end
        end
    end

    // Debug view of which registers still have an outstanding load.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            mask_s[r] = (pending_q[r] != CNT_ZERO);
        end
    end

    assign bus.o_stall        = stall_s;
    assign bus.o_bubble       = bubble_s;
    assign bus.o_pending_mask = mask_s;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] bubble_cnt_q;
    logic [31:0] lsu_cnt_q;

    // Saturating performance counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bubble_cnt_q <= 32'd0;
            lsu_cnt_q    <= 32'd0;
        end else begin
            if (bubble_s && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end else begin
                bubble_cnt_q <= bubble_cnt_q;
            end
            if (bus.i_stall_lsu && (lsu_cnt_q != 32'hFFFF_FFFF)) begin
                lsu_cnt_q <= lsu_cnt_q + 32'd1;
            end else begin
                lsu_cnt_q <= lsu_cnt_q;
            end
        end
    end

    assign bus.o_bubble_cnt    = bubble_cnt_q;
    assign bus.o_lsu_stall_cnt = lsu_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Table-driven bench for hazard_scoreboard with LOAD_LAT = 1, 2 and 3 instances
// sharing one stimulus; expectations flow through a queue to the sample point.
module tb_hazard_scoreboard;
    typedef struct {
        int          lat;
        bit          rst;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [4:0]  rd;
        logic        wren;
        logic [1:0]  wb;
        logic        valid;
        logic        lsu;
        logic        flush;
        logic        stall;
        logic        bubble;
        logic [31:0] mask;
    } vec_t;

    typedef struct {
        int          lat;
        int          idx;
        logic        stall;
        logic        bubble;
        logic [31:0] mask;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  rs1_r = 5'd0, rs2_r = 5'd0, rd_r = 5'd0;
    logic        u1_r = 1'b0, u2_r = 1'b0, wren_r = 1'b0, valid_r = 1'b0;
    logic        lsu_r = 1'b0, flush_r = 1'b0;
    logic [1:0]  wb_r = 2'd0;
    logic [2:0]  stall_s, bubble_s;
    logic [31:0] mask_s [3];
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] bcnt_s [3];
    logic [31:0] lcnt_s [3];
`endif

    int   checks = 0;
    int   failures = 0;
    vec_t tbl[$];
    exp_t exp_q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        hazard_scoreboard_if #(.REG_ADDR_W(5)) bus ();
        assign bus.i_rs1_addr_decode = rs1_r;
        assign bus.i_rs2_addr_decode = rs2_r;
        assign bus.i_rs1_used_decode = u1_r;
        assign bus.i_rs2_used_decode = u2_r;
        assign bus.i_rd_addr_execute = rd_r;
        assign bus.i_rd_wren_execute = wren_r;
        assign bus.i_wb_sel_execute  = wb_r;
        assign bus.i_valid_execute   = valid_r;
        assign bus.i_stall_lsu       = lsu_r;
        assign bus.i_flush           = flush_r;
        assign stall_s[g]  = bus.o_stall;
        assign bubble_s[g] = bus.o_bubble;
        assign mask_s[g]   = bus.o_pending_mask;
`ifdef HAZARD_PERF_CNT_EN
        assign bcnt_s[g] = bus.o_bubble_cnt;
        assign lcnt_s[g] = bus.o_lsu_stall_cnt;
`endif
        hazard_scoreboard #(.REG_ADDR_W(5), .LOAD_LAT(g + 1), .LOAD_WB_SEL(2'b00)) u_dut (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .bus     (bus)
        );
    end

    function automatic vec_t mk(input int lat, input bit rst, input int rs1, input bit u1,
                                input int rs2, input bit u2, input int rd, input bit wren,
                                input int wb, input bit valid, input bit lsu, input bit flush,
                                input bit stall, input bit bubble, input logic [31:0] mask);
        vec_t v;
        v.lat = lat; v.rst = rst; v.rs1 = 5'(rs1); v.u1 = u1; v.rs2 = 5'(rs2); v.u2 = u2;
        v.rd = 5'(rd); v.wren = wren; v.wb = 2'(wb); v.valid = valid; v.lsu = lsu;
        v.flush = flush; v.stall = stall; v.bubble = bubble; v.mask = mask;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] actual=%h required=%h", name, idx, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rs1_r = 5'd0; rs2_r = 5'd0; rd_r = 5'd0; u1_r = 1'b0; u2_r = 1'b0;
        wren_r = 1'b0; valid_r = 1'b0; wb_r = 2'd0; lsu_r = 1'b0; flush_r = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        exp_t got;
        if (v.rst) do_reset();
        @(posedge clk);
        #1;
        rs1_r = v.rs1; u1_r = v.u1; rs2_r = v.rs2; u2_r = v.u2; rd_r = v.rd;
        wren_r = v.wren; wb_r = v.wb; valid_r = v.valid; lsu_r = v.lsu; flush_r = v.flush;
        e.lat = v.lat; e.idx = idx; e.stall = v.stall; e.bubble = v.bubble; e.mask = v.mask;
        exp_q.push_back(e);
        @(negedge clk);
        got = exp_q.pop_front();
        check("stall", got.idx, 32'(stall_s[got.lat-1]), 32'(got.stall));
        check("bubble", got.idx, 32'(bubble_s[got.lat-1]), 32'(got.bubble));
        check("mask", got.idx, mask_s[got.lat-1], got.mask);
    endtask

    initial begin
        // LOAD_LAT=1: single-cycle EX match, never any pending entries
        tbl.push_back(mk(1,1,  5,1,  0,0,  5,1,0,1, 0,0, 1,1, 32'h0));
        tbl.push_back(mk(1,0,  5,1,  0,0,  0,0,0,0, 0,0, 0,0, 32'h0));
        tbl.push_back(mk(1,0,  5,1,  0,0,  5,1,1,1, 0,0, 0,0, 32'h0));
        tbl.push_back(mk(1,0,  0,0,  6,1,  6,1,0,1, 0,0, 1,1, 32'h0));
        tbl.push_back(mk(1,0, 10,1, 10,1, 10,1,0,1, 0,0, 1,1, 32'h0));
        tbl.push_back(mk(1,0,  3,1, 11,1, 11,1,0,1, 0,0, 1,1, 32'h0));
        tbl.push_back(mk(1,0,  5,1,  0,0,  5,0,0,1, 0,0, 0,0, 32'h0));
        tbl.push_back(mk(1,0,  5,1,  0,0,  5,1,0,0, 0,0, 0,0, 32'h0));
        // x0 load, unused source, flush, frozen flush
        tbl.push_back(mk(3,1,  0,1,  0,0,  0,1,0,1, 0,0, 0,0, 32'h0));
        tbl.push_back(mk(3,0,  8,0,  0,0,  8,1,0,1, 0,0, 0,0, 32'h0));
        tbl.push_back(mk(3,0,  0,0,  0,0,  0,0,0,0, 0,0, 0,0, 32'h100));
        tbl.push_back(mk(3,0,  4,1,  0,0,  4,1,0,1, 0,1, 0,0, 32'h100));
        tbl.push_back(mk(3,0,  4,1,  0,0,  0,0,0,0, 0,0, 0,0, 32'h0));
        tbl.push_back(mk(3,0,  4,1,  0,0,  4,1,0,1, 1,1, 1,0, 32'h0));
        tbl.push_back(mk(3,0,  4,1,  0,0,  0,0,0,0, 0,0, 0,0, 32'h0));
        // ALU overwrite of a pending load destination
        tbl.push_back(mk(2,1,  1,1,  0,0,  9,1,0,1, 0,0, 0,0, 32'h0));
        tbl.push_back(mk(2,0,  3,1,  0,0,  9,1,1,1, 0,0, 0,0, 32'h200));
        tbl.push_back(mk(2,0,  9,1,  0,0,  0,0,0,0, 0,0, 0,0, 32'h0));
        tbl.push_back(mk(3,1,  1,1,  0,0,  9,1,0,1, 0,0, 0,0, 32'h0));
        tbl.push_back(mk(3,0,  3,1,  0,0,  9,1,1,1, 0,0, 0,0, 32'h200));
        tbl.push_back(mk(3,0,  9,1,  0,0,  0,0,0,0, 0,0, 0,0, 32'h0));
        // LOAD_LAT=3: three bubbles for an immediate dependant
        tbl.push_back(mk(3,1,  7,1,  0,0,  7,1,0,1, 0,0, 1,1, 32'h0));
        tbl.push_back(mk(3,0,  7,1,  0,0,  0,0,0,0, 0,0, 1,1, 32'h80));
        tbl.push_back(mk(3,0,  7,1,  0,0,  0,0,0,0, 0,0, 1,1, 32'h80));
        tbl.push_back(mk(3,0,  7,1,  0,0,  0,0,0,0, 0,0, 0,0, 32'h0));
        // LOAD_LAT=3 with a 4-cycle LSU freeze mid-countdown (keep last)
        tbl.push_back(mk(3,1,  7,1,  0,0,  7,1,0,1, 0,0, 1,1, 32'h0));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(3,0, 7,1, 0,0, 0,0,0,0, 1,0, 1,0, 32'h80));
        tbl.push_back(mk(3,0,  7,1,  0,0,  0,0,0,0, 0,0, 1,1, 32'h80));
        tbl.push_back(mk(3,0,  7,1,  0,0,  0,0,0,0, 0,0, 1,1, 32'h80));
        tbl.push_back(mk(3,0,  7,1,  0,0,  0,0,0,0, 0,0, 0,0, 32'h0));

        idle_inputs();
        #2;
        for (int g = 0; g < 3; g++) begin
            check("reset_mask", g, mask_s[g], 32'h0);
            check("reset_bubble", g, 32'(bubble_s[g]), 32'h0);
        end
        lsu_r = 1'b1;
        #1 check("reset_stall_lsu", 0, 32'(stall_s[0]), 32'h1);
        lsu_r = 1'b0;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

`ifdef HAZARD_PERF_CNT_EN
        @(posedge clk);
        #1;
        check("perf_bubble_cnt", 0, bcnt_s[2], 32'd3);
        check("perf_lsu_cnt", 0, lcnt_s[2], 32'd4);
`endif

        // Reset pulse while pending[12]=2 (held there by an LSU freeze)
        apply(mk(3,1, 0,0, 0,0, 12,1,0,1, 0,0, 0,0, 32'h0), 100);
        apply(mk(3,0, 0,0, 0,0,  0,0,0,0, 1,0, 1,0, 32'h1000), 101);
        apply(mk(3,0, 0,0, 0,0,  0,0,0,0, 1,0, 1,0, 32'h1000), 102);
`ifdef HAZARD_PERF_CNT_EN
        check("perf_lsu_pre_rst", 0, lcnt_s[2], 32'd1);
`endif
        #1;
        rs1_r = 5'd12; u1_r = 1'b1; rd_r = 5'd12; wren_r = 1'b1; wb_r = 2'd0; valid_r = 1'b1;
        rst_n = 1'b0;
        #1;
        check("midrst_mask", 0, mask_s[2], 32'h0);
        check("midrst_stall", 0, 32'(stall_s[2]), 32'h1);
        check("midrst_bubble", 0, 32'(bubble_s[2]), 32'h0);
        lsu_r = 1'b0;
        #1 check("midrst_stall_nolsu", 0, 32'(stall_s[2]), 32'h0);
`ifdef HAZARD_PERF_CNT_EN
        check("midrst_bubble_cnt", 0, bcnt_s[2], 32'd0);
        check("midrst_lsu_cnt", 0, lcnt_s[2], 32'd0);
`endif
        idle_inputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        apply(mk(3,0, 12,1, 0,0, 0,0,0,0, 0,0, 0,0, 32'h0), 103);

        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
